// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : FSM encoding; the spare code 2'd3 is never entered and
//             recovers to IDLE if it ever appears.
//   cnt_w   : width of the bit counter for a given operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit_cell.sv
// Single gate-level full adder used as the serial arithmetic cell.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g;
  logic t;

  xor u_p    (p, a, b);
  xor u_s    (s, p, cin);
  and u_g    (g, a, b);
  and u_t    (t, p, cin);
  or  u_cout (cout, g, t);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// one bit per clock, LSB first.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, accepted only while ready=1
//   a, b        : operands, sampled on the accepting edge
//   cin         : carry in (ignored when sub=1)
//   sub         : 0 = a+b+cin, 1 = a-b
//   ready       : high in IDLE
//   busy        : high in RUN
//   done        : one-cycle pulse when sum/cout/ovf are valid
//   sum         : result, held until the next operation completes
//   cout        : carry out of the MSB (subtract: 1 = no borrow)
//   ovf         : signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_nx;

  fa_bit_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  // New sum bits enter at the MSB so that after WIDTH shifts the LSB
  // computed first has arrived at bit 0.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_nx = s_bit;
    end else begin : g_wn
      assign sum_nx = {s_bit, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and force the carry in.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end

        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nx;
          carry  <= c_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // MSB step: 'carry' still holds the carry into the MSB, so
            // overflow is that XOR the carry out of the MSB.
            sum   <= sum_nx;
            cout  <= c_bit;
            ovf   <= carry ^ c_bit;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       sub1;
  logic       ready1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;
  logic       ovf1;

  int tests;
  int failed;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .sub   (sub1),
    .ready (ready1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic tcin, input logic tsub,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input string nm);
    logic [7:0] hold;
    logic       stable;
    int         n;
    hold   = sum;
    stable = 1'b1;
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    step();
    start = 1'b0;
    // Scramble operands during RUN; the result must not change.
    a = ~ta; b = ~tb_v; cin = ~tcin; sub = ~tsub;
    tests++;
    if (ready !== 1'b0 || busy !== 1'b1) begin
      failed++;
      $display("FAIL %s_accept: ready=%b busy=%b, required ready=0 busy=1", nm, ready, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      if (sum !== hold) stable = 1'b0;
      step();
      n++;
    end
    tests++;
    if (n !== 8) begin
      failed++;
      $display("FAIL %s_latency: done after %0d cycles, required 8", nm, n);
    end
    tests++;
    if (stable !== 1'b1) begin
      failed++;
      $display("FAIL %s_sum_stable: sum changed during RUN, required hold=%h", nm, hold);
    end
    tests++;
    if (sum !== es || cout !== ec || ovf !== eo) begin
      failed++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
               nm, sum, cout, ovf, es, ec, eo);
    end
    step();
    tests++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_return_idle: done=%b ready=%b, required done=0 ready=1", nm, done, ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    step();
    step();
    tests++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
        sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      failed++;
      $display("FAIL reset_w8: ready=%b busy=%b done=%b sum=%h cout=%b ovf=%b, required 1 0 0 00 0 0",
               ready, busy, done, sum, cout, ovf);
    end
    tests++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 ||
        sum1 !== 1'b0 || cout1 !== 1'b0 || ovf1 !== 1'b0) begin
      failed++;
      $display("FAIL reset_w1: ready=%b busy=%b done=%b sum=%b cout=%b ovf=%b, required 1 0 0 0 0 0",
               ready1, busy1, done1, sum1, cout1, ovf1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    run8(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
  endtask

  task automatic test_carry();
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    run8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_cin");
  endtask

  task automatic test_sub();
    run8(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
    run8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
  endtask

  task automatic test_start_ignored();
    int pulses;
    logic [7:0] got;
    pulses = 0;
    got = 8'hxx;
    a = 8'h5A; b = 8'h3C; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) begin pulses++; got = sum; end
      step();
    end
    a = 8'h01; b = 8'h01; start = 1'b1;
    tests++;
    if (ready !== 1'b0) begin
      failed++;
      $display("FAIL ignore_ready: ready=%b during RUN, required 0", ready);
    end
    step();
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (done === 1'b1) begin pulses++; got = sum; end
      step();
    end
    tests++;
    if (pulses !== 1) begin
      failed++;
      $display("FAIL ignore_pulses: %0d done pulses, required 1", pulses);
    end
    tests++;
    if (got !== 8'h96) begin
      failed++;
      $display("FAIL ignore_result: sum=%h, required 96", got);
    end
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    a = 8'h0F; b = 8'h0F; cin = 1'b0; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0 || ready !== 1'b1 ||
        busy !== 1'b0 || done !== 1'b0) begin
      failed++;
      $display("FAIL abort_clear: sum=%h cout=%b ovf=%b ready=%b busy=%b done=%b, required 00 0 0 1 0 0",
               sum, cout, ovf, ready, busy, done);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    tests++;
    if (pulses !== 0 || ready !== 1'b1) begin
      failed++;
      $display("FAIL abort_no_done: %0d done pulses ready=%b, required 0 pulses ready=1", pulses, ready);
    end
    run8(8'h21, 8'h12, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int n;
    int gap;
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin step(); n++; end
    tests++;
    if (done !== 1'b1 || sum !== 8'h03) begin
      failed++;
      $display("FAIL b2b_first: done=%b sum=%h, required done=1 sum=03", done, sum);
    end
    gap = 0;
    step(); gap++;
    while (done !== 1'b1 && gap < 20) begin step(); gap++; end
    tests++;
    if (gap !== 10 || sum !== 8'h03) begin
      failed++;
      $display("FAIL b2b_gap: gap=%0d sum=%h, required gap=10 sum=03", gap, sum);
    end
    start = 1'b0;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin step(); n++; end
    for (int i = 0; i < 12; i++) step();
    tests++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL b2b_idle: ready=%b busy=%b, required ready=1 busy=0", ready, busy);
    end
  endtask

  task automatic test_width1();
    logic [2:0] v;
    logic [1:0] exp;
    int n;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; sub1 = 1'b0; start1 = 1'b1;
      step();
      start1 = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 10) begin step(); n++; end
      tests++;
      if (n !== 1 || {cout1, sum1} !== exp || ovf1 !== (v[0] ^ exp[1])) begin
        failed++;
        $display("FAIL w1_abc%b: lat=%0d cout=%b sum=%b ovf=%b, required lat=1 cout=%b sum=%b ovf=%b",
                 v, n, cout1, sum1, ovf1, exp[1], exp[0], v[0] ^ exp[1]);
      end
      tests++;
      if (sum1 !== (v[2] ^ v[1] ^ v[0])) begin
        failed++;
        $display("FAIL w1_sumonly_abc%b: sum=%b, required %b", v, sum1, v[2] ^ v[1] ^ v[0]);
      end
      step();
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_width1();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
